// File: rtl/div_pkg.sv
// Shared types and constants for the iterative 32-bit restoring divider.
package div_pkg;

  localparam int unsigned DIV_W = 32;
  localparam int unsigned CNT_W = 5;
  localparam logic [DIV_W-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate: res = neg ? -val : val.
module div_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] val,
  input  logic             neg,
  output logic [WIDTH-1:0] res
);

  always_comb begin
    res = val;
    if (neg) begin
      res = ~val + WIDTH'(1);
    end
  end

endmodule

// File: rtl/seq_divider_32b.sv
// Iterative 32-bit restoring divider driving an external adder/subtractor, one quotient bit per clock.
// Optional signed support is compiled in with `define DIV_SIGNED_EN.
module seq_divider_32b
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             sign_op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_sub,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout
);

  div_state_e state_q, state_d;
  logic [DIV_W-1:0] r_q, r_d, q_q, q_d, d_q, d_d;
  logic [DIV_W-1:0] quot_q, quot_d, rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbz_q, dbz_d;

  logic             take;
  logic [DIV_W-1:0] shift_r, r_next, q_next;
  logic [DIV_W-1:0] dvd_mag, dvs_mag;

`ifdef DIV_SIGNED_EN
  logic             dvd_neg, dvs_neg;
  logic             neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic [DIV_W-1:0] quot_fix, rem_fix;

  assign dvd_neg = sign_op & dividend[DIV_W-1];
  assign dvs_neg = sign_op & divisor[DIV_W-1];

  div_sign_fix #(.WIDTH(DIV_W)) u_dvd_mag (.val(dividend), .neg(dvd_neg), .res(dvd_mag));
  div_sign_fix #(.WIDTH(DIV_W)) u_dvs_mag (.val(divisor),  .neg(dvs_neg), .res(dvs_mag));
  div_sign_fix #(.WIDTH(DIV_W)) u_quot_fix (.val(q_q), .neg(neg_q_q), .res(quot_fix));
  div_sign_fix #(.WIDTH(DIV_W)) u_rem_fix  (.val(r_q), .neg(neg_r_q), .res(rem_fix));
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
`endif

  // R[31] is the 33rd bit of the shifted partial remainder, so its presence guarantees the subtract succeeds.
  assign shift_r = {r_q[DIV_W-2:0], q_q[DIV_W-1]};
  assign take    = r_q[DIV_W-1] | add_cout;
  assign r_next  = take ? add_sum : shift_r;
  assign q_next  = {q_q[DIV_W-2:0], take};

  assign add_a       = shift_r;
  assign add_b       = d_q;
  assign add_sub     = 1'b1;
  assign in_ready    = ~rst & (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          r_d   = '0;
          q_d   = dvd_mag;
          d_d   = dvs_mag;
          cnt_d = '1;
`ifdef DIV_SIGNED_EN
          neg_q_d = dvd_neg ^ dvs_neg;
          neg_r_d = dvd_neg;
`endif
          if (divisor == '0) begin
            quot_d  = DIV0_QUOT;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            dbz_d   = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        r_d = r_next;
        q_d = q_next;
        if (cnt_q == '0) begin
`ifdef DIV_SIGNED_EN
          state_d = FIXUP;
`else
          quot_d  = q_next;
          rem_d   = r_next;
          state_d = DONE;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef DIV_SIGNED_EN
      FIXUP: begin
        quot_d  = quot_fix;
        rem_d   = rem_fix;
        state_d = DONE;
      end
`endif
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_divider_32b.sv
// Self-checking bench for seq_divider_32b with a behavioural adder and an arithmetic reference model.
module tb_seq_divider_32b;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic        div_by_zero, add_sub, add_cout;
  logic [31:0] dividend, divisor, quotient, remainder, add_a, add_b, add_sum;
`ifdef DIV_SIGNED_EN
  logic        sign_op;
  localparam int RUN_LAT = 33;
`else
  localparam int RUN_LAT = 32;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // External carry-lookahead adder/subtractor behaviour; cout = 1 means no borrow.
  assign {add_cout, add_sum} = add_sub ? ({1'b0, add_a} + {1'b0, ~add_b} + 33'd1)
                                       : ({1'b0, add_a} + {1'b0, add_b});

  seq_divider_32b #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
`ifdef DIV_SIGNED_EN
    .sign_op    (sign_op),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_sub    (add_sub),
    .add_sum    (add_sum),
    .add_cout   (add_cout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
    z = (b == 32'd0);
    if (z) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
  endfunction

  // One full transaction; hold > 0 keeps out_ready low for that many cycles after DONE.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                         input int hold, input string tag);
    logic [31:0] eq, er, q0, r0;
    logic        ez;
    int          lat, exp_lat;
    bit          busy_rdy, unstable;
    ref_div(a, b, s, eq, er, ez);
    exp_lat = ez ? 0 : RUN_LAT;
    out_ready = (hold == 0);
    @(negedge clk);
    for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    dividend = a;
    divisor  = b;
`ifdef DIV_SIGNED_EN
    sign_op  = s;
`endif
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    // Garbage offered while busy must be ignored.
    dividend = $urandom;
    divisor  = $urandom;
    lat      = 0;
    busy_rdy = 1'b0;
    while (!out_valid && lat < 80) begin
      busy_rdy |= in_ready;
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_in_ready"}, {31'd0, busy_rdy}, 32'd0);
    check({tag, "_quot"}, quotient, eq);
    check({tag, "_rem"}, remainder, er);
    check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
    if (hold > 0) begin
      q0 = quotient;
      r0 = remainder;
      unstable = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        if (!out_valid || in_ready || quotient !== q0 || remainder !== r0) unstable = 1'b1;
      end
      check({tag, "_hold_stable"}, {31'd0, unstable}, 32'd0);
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit          rs, rose;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
`ifdef DIV_SIGNED_EN
    sign_op   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_quot", quotient, 32'd0);
    check("rst_rem", remainder, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    check("rst_add_a", add_a, 32'd0);
    check("rst_add_b", add_b, 32'd0);
    check("rst_add_sub", {31'd0, add_sub}, 32'd1);
    rst = 1'b0;

    run_div(32'd100, 32'd7, 1'b0, 0, "d100_7");
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 0, "max_1");
    run_div(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 0, "max_r31");
    run_div(32'd5, 32'd0, 1'b0, 0, "div0");
    run_div(32'h1234_5678, 32'd9, 1'b0, 10, "stall");

    // Reset during RUN: result discarded and out_valid never rises.
    out_ready = 1'b1;
    @(negedge clk);
    dividend = 32'd1000;
    divisor  = 32'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (16) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    rst  = 1'b0;
    rose = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      rose |= out_valid;
    end
    check("midrst_no_valid", {31'd0, rose}, 32'd0);
    check("midrst_idle", {31'd0, in_ready}, 32'd1);

`ifdef DIV_SIGNED_EN
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, "s_m7_2");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "s_min_m1");
`endif

    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      case (n % 4)
        0: rb = $urandom_range(1, 255);
        1: rb = $urandom;
        2: rb = (n % 8 == 2) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
        default: rb = 32'h8000_0000 | $urandom;
      endcase
`ifdef DIV_SIGNED_EN
      rs = $urandom_range(0, 1) == 1;
`else
      rs = 1'b0;
`endif
      run_div(ra, rb, rs, 0, $sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
